mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 5, operand width of the shared multiplier.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 64, max cycles in WAIT before abort (used only with the macro in REQ-026).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cl_req  input  NREQ  per-client request, held high until that client's cl_done.
REQ-007 cl_a, cl_b  input  NREQ*WIDTH each  per-client operands; client i occupies bits [i*WIDTH +: WIDTH].
REQ-008 cl_gnt  output  NREQ  one-hot grant, high from issue until completion.
REQ-009 cl_done  output  NREQ  one-hot, one-cycle completion pulse.
REQ-010 cl_ab  output  2*WIDTH  result, valid while any cl_done bit is high.
REQ-011 cl_err  output  1  abort flag, valid with cl_done.
REQ-012 m_req, m_a, m_b  output  1/WIDTH/WIDTH  multiplier request and operands.
REQ-013 m_rdy, m_done, m_ab  input  1/1/2*WIDTH  multiplier idle flag, one-cycle completion pulse, product.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-015 IDLE: if any cl_req bit is high and m_rdy=1, select a winner round-robin starting at pointer ptr, latch that client's operands into m_a/m_b, set its cl_gnt bit, and go to ISSUE; otherwise remain in IDLE.
REQ-016 ISSUE: m_req=1 for exactly one cycle, then go to WAIT.
REQ-017 WAIT: on m_done=1, capture m_ab into cl_ab and go to RESP; m_a/m_b SHALL stay stable throughout ISSUE and WAIT.
REQ-018 RESP: pulse the winner's cl_done for one cycle, clear cl_gnt, set ptr = (winner+1) mod NREQ, and return to IDLE.
REQ-019 Latency: a request seen in IDLE at edge 0 gives cl_gnt and m_req at edge 1; m_done at edge k gives cl_done at edge k+1; minimum back-to-back turnaround SHALL be one IDLE cycle.
REQ-020 Fairness: under continuous requests from all clients, each client SHALL be granted exactly once per NREQ transactions.
REQ-021 A cl_req deasserted before grant SHALL be treated as withdrawn; a cl_req deasserted after grant SHALL NOT cancel the transaction, and cl_done SHALL still pulse.
REQ-022 m_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-023 m_rdy=0 in IDLE SHALL block grant; ptr SHALL be unchanged.

Reset
REQ-024 On rst=1, the FSM SHALL enter IDLE immediately, with ptr=0, cl_gnt=0, cl_done=0, cl_ab=0, cl_err=0, m_req=0, m_a=0 and m_b=0; the timeout counter SHALL be 0.
REQ-025 Reset mid-transaction SHALL drop the transaction with no cl_done; a later stale m_done SHALL be ignored per REQ-022.

Configuration
REQ-026 Macro MULT_ARBITER_TIMEOUT_EN defined: a counter SHALL run in WAIT; if m_done has not arrived after TIMEOUT cycles, go to RESP with cl_ab=0 and cl_err=1.
REQ-027 Macro not defined: WAIT SHALL wait indefinitely, cl_err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-028 Single request: client 2 requests with a=3, b=7, multiplier done 5 cycles after m_req -> cl_gnt[2] and m_req at +1, cl_done[2] with cl_ab=21, cl_err=0.
REQ-029 All four clients request continuously, ptr=0 -> grant order 0,1,2,3,0; each product correct (e.g. client 3: 31*31 -> cl_ab=961).
REQ-030 Client 1 drops cl_req while client 0 is being serviced -> client 1 not granted; the next grant goes to client 2.
REQ-031 rst pulsed in WAIT, then m_done arrives -> no cl_done; state IDLE; ptr=0.
REQ-032 With MULT_ARBITER_TIMEOUT_EN and TIMEOUT=64, m_done withheld -> cl_done at 64+1 cycles after entering WAIT with cl_err=1 and cl_ab=0; without the macro, no response until m_done.
REQ-033 m_rdy held 0 with requests pending -> no cl_gnt and no m_req; grant follows within one cycle of m_rdy rising.

Source files
------------

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Purpose:
//   Shares a single multiplier among NREQ clients. A round-robin arbiter
//   picks one requesting client while the multiplier is idle. It latches that
//   client's operands, issues a one-cycle multiplier request and waits for the
//   product. It then returns the product with a one-cycle completion pulse
//   to the winning client.
//
// Optional feature:
//   MULT_ARBITER_TIMEOUT_EN - when defined, a transaction that waits TIMEOUT
//   cycles without m_done is aborted. The response carries cl_ab=0 and
//   cl_err=1. When undefined, the wait is unbounded and cl_err is tied low.
//
// Parameters:
//   WIDTH    operand width of the shared multiplier
//   NREQ     number of clients (2..8)
//   TIMEOUT  abort limit in WAIT cycles (only used with the macro above)
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      asynchronous active-high reset
//   cl_req   per-client request, held until that client's cl_done
//   cl_a     per-client operand A, client i at [i*WIDTH +: WIDTH]
//   cl_b     per-client operand B, client i at [i*WIDTH +: WIDTH]
//   cl_gnt   one-hot grant, high from issue until completion
//   cl_done  one-hot one-cycle completion pulse
//   cl_ab    product, valid while cl_done is non-zero
//   cl_err   abort flag, valid with cl_done
//   m_req    one-cycle multiplier request
//   m_a/m_b  multiplier operands, stable from issue until the response
//   m_rdy    multiplier idle flag
//   m_done   multiplier one-cycle completion pulse
//   m_ab     multiplier product
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int WIDTH   = 5,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         cl_req,
    input  logic [NREQ*WIDTH-1:0]   cl_a,
    input  logic [NREQ*WIDTH-1:0]   cl_b,
    output logic [NREQ-1:0]         cl_gnt,
    output logic [NREQ-1:0]         cl_done,
    output logic [2*WIDTH-1:0]      cl_ab,
    output logic                    cl_err,
    output logic                    m_req,
    output logic [WIDTH-1:0]        m_a,
    output logic [WIDTH-1:0]        m_b,
    input  logic                    m_rdy,
    input  logic                    m_done,
    input  logic [2*WIDTH-1:0]      m_ab
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;

    // Unpacked views of the client operand buses.
    logic [WIDTH-1:0]  a_arr [NREQ];
    logic [WIDTH-1:0]  b_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = cl_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = cl_b[gi*WIDTH +: WIDTH];
    end

    // Index of the lowest set bit of v (0 when v is empty).
    function automatic logic [PTR_W-1:0] lowest_set(input logic [NREQ-1:0] v);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin selection as a masked priority encoder. Requests at or
    // above ptr take priority. If none exist, the search wraps to the
    // lowest-numbered requester.
    logic [NREQ-1:0]   upper_mask;
    logic [NREQ-1:0]   req_hi;
    logic [PTR_W-1:0]  pick;
    logic              any_req;
    logic [PTR_W-1:0]  ptr_next;

    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            upper_mask[i] = (PTR_W'(i) >= ptr);
        end
        req_hi  = cl_req & upper_mask;
        any_req = |cl_req;
        pick    = (|req_hi) ? lowest_set(req_hi) : lowest_set(cl_req);
    end

    // ptr advances past the client just served, wrapping for any NREQ.
    assign ptr_next = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;

`ifdef MULT_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]  to_cnt;
`else
    assign cl_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            cl_gnt  <= '0;
            cl_done <= '0;
            cl_ab   <= '0;
            m_req   <= 1'b0;
            m_a     <= '0;
            m_b     <= '0;
`ifdef MULT_ARBITER_TIMEOUT_EN
            cl_err  <= 1'b0;
            to_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A busy multiplier blocks the grant and leaves ptr unchanged.
                    if (any_req && m_rdy) begin
                        win    <= pick;
                        cl_gnt <= onehot(pick);
                        m_a    <= a_arr[pick];
                        m_b    <= b_arr[pick];
                        m_req  <= 1'b1;
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    // m_done here is stale and deliberately ignored.
                    m_req <= 1'b0;
                    state <= WAIT;
`ifdef MULT_ARBITER_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end

                WAIT: begin
                    if (m_done) begin
                        cl_ab   <= m_ab;
                        cl_done <= onehot(win);
`ifdef MULT_ARBITER_TIMEOUT_EN
                        cl_err  <= 1'b0;
`endif
                        state   <= RESP;
                    end
`ifdef MULT_ARBITER_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        // Abort: answer the client with an error and no product.
                        cl_ab   <= '0;
                        cl_err  <= 1'b1;
                        cl_done <= onehot(win);
                        state   <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    cl_done <= '0;
                    cl_gnt  <= '0;
                    ptr     <= ptr_next;
`ifdef MULT_ARBITER_TIMEOUT_EN
                    cl_err  <= 1'b0;
                    to_cnt  <= '0;
`endif
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
